// File: rtl/branch_ctrl.sv
// branch_ctrl: EX-stage branch resolution and redirect controller.
// Evaluates conditional branches and jumps, detects mispredictions
// against the fetch-time prediction and issues a registered redirect
// and flush to fetch over a ready/valid handshake. Keeps saturating
// counters of resolved branches and mispredictions.
// Optional feature macro: BRANCH_CTRL_BHT_EN adds a 2-bit saturating
// branch history table used for fetch-time prediction. Without it the
// front end predicts static not-taken.
module branch_ctrl #(
   parameter int unsigned BHT_IDX_W = 4,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_ex_valid,
   input  logic             i_ex_is_br,
   input  logic             i_ex_is_jmp,
   input  logic [2:0]       i_ex_funct3,
   input  logic [31:0]      i_ex_pc,
   input  logic [31:0]      i_ex_target,
   input  logic             i_ex_pred_taken,
   output logic             o_br_un,
   input  logic             i_br_less,
   input  logic             i_br_equal,
   input  logic [31:0]      i_if_pc,
   output logic             o_if_pred_taken,
   output logic             o_redirect_valid,
   output logic [31:0]      o_redirect_pc,
   input  logic             i_redirect_ready,
   output logic             o_flush,
   output logic             o_stall,
   output logic [CNT_W-1:0] o_br_cnt,
   output logic [CNT_W-1:0] o_mispred_cnt
);

   typedef enum logic {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        redirect_pc_q, redirect_pc_d;
   logic               flush_q, flush_d;
   logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;

   logic               br_cond;
   logic               legal_br;
   logic               taken;
   logic               resolve;
   logic               mispredict;
   logic [31:0]        next_pc;

   assign o_br_un = i_ex_funct3[1];

   // Branch condition evaluation, resolve event and corrected next PC
   always_comb begin
      br_cond = 1'b0;
      unique case (i_ex_funct3)
         3'b000:         br_cond = i_br_equal;
         3'b001:         br_cond = ~i_br_equal;
         3'b100, 3'b110: br_cond = i_br_less;
         3'b101, 3'b111: br_cond = ~i_br_less;
         default:        br_cond = 1'b0;
      endcase
      legal_br = i_ex_is_br & (i_ex_funct3[2:1] != 2'b01);
      taken    = i_ex_is_jmp | (legal_br & br_cond);
      resolve  = i_ex_valid & (i_ex_is_br | i_ex_is_jmp) & (state_q == IDLE);
`ifdef BRANCH_CTRL_BHT_EN
      mispredict = resolve & (taken != i_ex_pred_taken);
`else
      // Static not-taken: only a taken instruction can be mispredicted.
      mispredict = resolve & taken;
`endif
      next_pc = taken ? i_ex_target : (i_ex_pc + 32'd4);
   end

   // Redirect FSM next-state logic and redirect PC capture
   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      flush_d       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mispredict) begin
               state_d       = REDIRECT;
               redirect_pc_d = next_pc;
               flush_d       = 1'b1;
            end
         end
         REDIRECT: begin
            if (i_redirect_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Saturating performance counter next values
   always_comb begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (resolve && legal_br && (br_cnt_q != '1)) begin
         br_cnt_d = br_cnt_q + CNT_W'(1);
      end
      if (mispredict && (mis_cnt_q != '1)) begin
         mis_cnt_d = mis_cnt_q + CNT_W'(1);
      end
   end

   // State, redirect and counter registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= IDLE;
         redirect_pc_q <= '0;
         flush_q       <= 1'b0;
         br_cnt_q      <= '0;
         mis_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
         flush_q       <= flush_d;
         br_cnt_q      <= br_cnt_d;
         mis_cnt_q     <= mis_cnt_d;
      end
   end

   assign o_redirect_valid = (state_q == REDIRECT);
   assign o_redirect_pc    = redirect_pc_q;
   assign o_flush          = flush_q;
   assign o_stall          = (state_q == REDIRECT) & ~i_redirect_ready;
   assign o_br_cnt         = br_cnt_q;
   assign o_mispred_cnt    = mis_cnt_q;

`ifdef BRANCH_CTRL_BHT_EN
   localparam int unsigned BHT_N = 1 << BHT_IDX_W;

   logic [1:0]           bht_q [BHT_N];
   logic [BHT_IDX_W-1:0] ex_idx;
   logic [BHT_IDX_W-1:0] if_idx;
   logic                 bht_upd;
   logic                 unused_bht;

   assign ex_idx     = i_ex_pc[BHT_IDX_W+1:2];
   assign if_idx     = i_if_pc[BHT_IDX_W+1:2];
   assign bht_upd    = resolve & legal_br;
   assign unused_bht = ^{i_if_pc[31:BHT_IDX_W+2], i_if_pc[1:0]};

   // Lookup reads the registered table, so a same-cycle update is not bypassed
   assign o_if_pred_taken = bht_q[if_idx][1];

   // BHT storage: reset to weakly not-taken, saturating update on legal branches
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int unsigned i = 0; i < BHT_N; i++) begin
            bht_q[i[BHT_IDX_W-1:0]] <= 2'b01;
         end
      end else if (bht_upd) begin
         if (taken && (bht_q[ex_idx] != 2'b11)) begin
            bht_q[ex_idx] <= bht_q[ex_idx] + 2'd1;
         end else if (!taken && (bht_q[ex_idx] != 2'b00)) begin
            bht_q[ex_idx] <= bht_q[ex_idx] - 2'd1;
         end
      end
   end
`else
   logic unused_bht;

   assign unused_bht      = ^{i_if_pc, i_ex_pred_taken};
   assign o_if_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl (8-bit counters so the
// saturation sequence stays short). Expectations depend on whether
// BRANCH_CTRL_BHT_EN is defined.
module tb_branch_ctrl;

`ifdef BRANCH_CTRL_BHT_EN
   localparam bit BHT = 1'b1;
`else
   localparam bit BHT = 1'b0;
`endif
   localparam int unsigned CW = 8;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic          i_ex_valid, i_ex_is_br, i_ex_is_jmp;
   logic [2:0]    i_ex_funct3;
   logic [31:0]   i_ex_pc, i_ex_target;
   logic          i_ex_pred_taken;
   logic          o_br_un;
   logic          i_br_less, i_br_equal;
   logic [31:0]   i_if_pc;
   logic          o_if_pred_taken;
   logic          o_redirect_valid;
   logic [31:0]   o_redirect_pc;
   logic          i_redirect_ready;
   logic          o_flush, o_stall;
   logic [CW-1:0] o_br_cnt, o_mispred_cnt;

   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned exp_br = 0;
   int unsigned exp_mis = 0;

   branch_ctrl #(.BHT_IDX_W(4), .CNT_W(CW)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_ex_valid(i_ex_valid), .i_ex_is_br(i_ex_is_br), .i_ex_is_jmp(i_ex_is_jmp),
      .i_ex_funct3(i_ex_funct3), .i_ex_pc(i_ex_pc), .i_ex_target(i_ex_target),
      .i_ex_pred_taken(i_ex_pred_taken), .o_br_un(o_br_un),
      .i_br_less(i_br_less), .i_br_equal(i_br_equal),
      .i_if_pc(i_if_pc), .o_if_pred_taken(o_if_pred_taken),
      .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
      .i_redirect_ready(i_redirect_ready), .o_flush(o_flush), .o_stall(o_stall),
      .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear_ex();
      i_ex_valid = 1'b0; i_ex_is_br = 1'b0; i_ex_is_jmp = 1'b0;
      i_ex_funct3 = 3'b000; i_ex_pc = '0; i_ex_target = '0;
      i_ex_pred_taken = 1'b0; i_br_less = 1'b0; i_br_equal = 1'b0;
   endtask

   task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic pred, input logic less, input logic eq);
      i_ex_valid = 1'b1; i_ex_is_br = 1'b1; i_ex_is_jmp = 1'b0;
      i_ex_funct3 = f3; i_ex_pc = pc; i_ex_target = tgt;
      i_ex_pred_taken = pred; i_br_less = less; i_br_equal = eq;
   endtask

   task automatic jmp(input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
      clear_ex();
      i_ex_valid = 1'b1; i_ex_is_jmp = 1'b1;
      i_ex_pc = pc; i_ex_target = tgt; i_ex_pred_taken = pred;
   endtask

   initial begin
      clear_ex();
      i_reset = 1'b1; i_redirect_ready = 1'b1; i_if_pc = 32'h40;
      tick(); tick();
      chk("rst_valid", {31'd0, o_redirect_valid}, 32'd0);
      chk("rst_pc", o_redirect_pc, 32'd0);
      chk("rst_flush", {31'd0, o_flush}, 32'd0);
      chk("rst_stall", {31'd0, o_stall}, 32'd0);
      chk("rst_brcnt", 32'(o_br_cnt), 32'd0);
      chk("rst_miscnt", 32'(o_mispred_cnt), 32'd0);
      chk("rst_ifpred", {31'd0, o_if_pred_taken}, 32'd0);
      i_reset = 1'b0;
      tick();

      // BLT taken, predicted not-taken
      br(3'b100, 32'h100, 32'h80, 1'b0, 1'b1, 1'b0);
      #1 chk("blt_un", {31'd0, o_br_un}, 32'd0);
      chk("blt_no_early_valid", {31'd0, o_redirect_valid}, 32'd0);
      tick(); clear_ex();
      exp_br = 1; exp_mis = 1;
      chk("blt_valid", {31'd0, o_redirect_valid}, 32'd1);
      chk("blt_pc", o_redirect_pc, 32'h80);
      chk("blt_flush", {31'd0, o_flush}, 32'd1);
      chk("blt_stall", {31'd0, o_stall}, 32'd0);
      chk("blt_miscnt", 32'(o_mispred_cnt), exp_mis);
      chk("blt_brcnt", 32'(o_br_cnt), exp_br);
      tick();
      chk("blt_idle", {31'd0, o_redirect_valid}, 32'd0);
      chk("blt_flush_off", {31'd0, o_flush}, 32'd0);

      // BGEU not taken (less=1), predicted taken
      br(3'b111, 32'h200, 32'h300, 1'b1, 1'b1, 1'b0);
      #1 chk("bgeu_un", {31'd0, o_br_un}, 32'd1);
      tick(); clear_ex();
      exp_br++; exp_mis += BHT ? 1 : 0;
      chk("bgeu_valid", {31'd0, o_redirect_valid}, BHT ? 32'd1 : 32'd0);
      chk("bgeu_miscnt", 32'(o_mispred_cnt), exp_mis);
      chk("bgeu_brcnt", 32'(o_br_cnt), exp_br);
      chk("bgeu_pc", o_redirect_pc, BHT ? 32'h204 : 32'h80);
      tick();

      // BEQ taken, predicted taken
      br(3'b000, 32'h300, 32'h400, 1'b1, 1'b0, 1'b1);
      tick(); clear_ex();
      exp_br++; exp_mis += BHT ? 0 : 1;
      chk("beq_valid", {31'd0, o_redirect_valid}, BHT ? 32'd0 : 32'd1);
      chk("beq_miscnt", 32'(o_mispred_cnt), exp_mis);
      chk("beq_brcnt", 32'(o_br_cnt), exp_br);
      tick();
      chk("beq_idle", {31'd0, o_redirect_valid}, 32'd0);

      // BNE taken with ready held low for three redirect cycles
      i_redirect_ready = 1'b0;
      br(3'b001, 32'h500, 32'h600, 1'b0, 1'b0, 1'b0);
      tick();
      br(3'b000, 32'h700, 32'h800, 1'b0, 1'b0, 1'b1);
      exp_br++; exp_mis++;
      for (int c = 1; c <= 3; c++) begin
         #1;
         chk($sformatf("wait%0d_valid", c), {31'd0, o_redirect_valid}, 32'd1);
         chk($sformatf("wait%0d_stall", c), {31'd0, o_stall}, 32'd1);
         chk($sformatf("wait%0d_flush", c), {31'd0, o_flush}, (c == 1) ? 32'd1 : 32'd0);
         chk($sformatf("wait%0d_pc", c), o_redirect_pc, 32'h600);
         if (c < 3) tick();
      end
      clear_ex();
      i_redirect_ready = 1'b1;
      #1;
      chk("acc_valid", {31'd0, o_redirect_valid}, 32'd1);
      chk("acc_stall", {31'd0, o_stall}, 32'd0);
      chk("acc_pc", o_redirect_pc, 32'h600);
      tick();
      chk("acc_idle", {31'd0, o_redirect_valid}, 32'd0);
      chk("acc_brcnt", 32'(o_br_cnt), exp_br);
      chk("acc_miscnt", 32'(o_mispred_cnt), exp_mis);

      // Illegal funct3 010
      br(3'b010, 32'h900, 32'hA00, 1'b0, 1'b1, 1'b1);
      tick(); clear_ex();
      chk("ill_valid", {31'd0, o_redirect_valid}, 32'd0);
      chk("ill_brcnt", 32'(o_br_cnt), exp_br);
      chk("ill_miscnt", 32'(o_mispred_cnt), exp_mis);

      // JAL predicted not-taken
      jmp(32'h40, 32'h1000, 1'b0);
      tick(); clear_ex();
      exp_mis++;
      chk("jal_valid", {31'd0, o_redirect_valid}, 32'd1);
      chk("jal_pc", o_redirect_pc, 32'h1000);
      chk("jal_miscnt", 32'(o_mispred_cnt), exp_mis);
      chk("jal_brcnt", 32'(o_br_cnt), exp_br);
      tick();

      // Reset while a redirect is pending
      br(3'b100, 32'h100, 32'h80, 1'b0, 1'b1, 1'b0);
      tick(); clear_ex();
      i_redirect_ready = 1'b0;
      #1 chk("mid_valid", {31'd0, o_redirect_valid}, 32'd1);
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      chk("mid_rst_valid", {31'd0, o_redirect_valid}, 32'd0);
      chk("mid_rst_pc", o_redirect_pc, 32'd0);
      chk("mid_rst_flush", {31'd0, o_flush}, 32'd0);
      chk("mid_rst_stall", {31'd0, o_stall}, 32'd0);
      chk("mid_rst_brcnt", 32'(o_br_cnt), 32'd0);
      chk("mid_rst_miscnt", 32'(o_mispred_cnt), 32'd0);
      chk("mid_rst_ifpred", {31'd0, o_if_pred_taken}, 32'd0);
      i_redirect_ready = 1'b1;

`ifdef BRANCH_CTRL_BHT_EN
      // BHT training at pc 0x40 (index 0), lookups at 0x40 and aliased 0x80
      i_if_pc = 32'h40;
      br(3'b000, 32'h40, 32'h90, 1'b0, 1'b0, 1'b1);
      #1 chk("bht_same_cycle_old", {31'd0, o_if_pred_taken}, 32'd0);
      tick(); clear_ex();
      chk("bht_after1", {31'd0, o_if_pred_taken}, 32'd1);
      tick();
      br(3'b000, 32'h40, 32'h90, 1'b1, 1'b0, 1'b1);
      tick(); clear_ex();
      chk("bht_after2_nomis", {31'd0, o_redirect_valid}, 32'd0);
      chk("bht_after2", {31'd0, o_if_pred_taken}, 32'd1);
      i_if_pc = 32'h80;
      #1 chk("bht_alias", {31'd0, o_if_pred_taken}, 32'd1);
      i_if_pc = 32'h44;
      #1 chk("bht_other_idx", {31'd0, o_if_pred_taken}, 32'd0);
      i_if_pc = 32'h40;
      // Two not-taken resolves: 11 -> 10 -> 01
      br(3'b000, 32'h40, 32'h90, 1'b1, 1'b0, 1'b0);
      tick(); clear_ex();
      chk("bht_dec1", {31'd0, o_if_pred_taken}, 32'd1);
      tick();
      br(3'b000, 32'h40, 32'h90, 1'b1, 1'b0, 1'b0);
      tick(); clear_ex();
      chk("bht_dec2", {31'd0, o_if_pred_taken}, 32'd0);
      tick();
      // A jump at the same index must not train the table
      jmp(32'h40, 32'h2000, 1'b0);
      tick(); clear_ex();
      chk("bht_jal_pc", o_redirect_pc, 32'h2000);
      chk("bht_jal_noupd", {31'd0, o_if_pred_taken}, 32'd0);
      tick();
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
`endif

      // Counter saturation with 2^CW+2 mispredicts
      for (int n = 0; n < (1 << CW) + 2; n++) begin
         br(3'b100, 32'h100, 32'h80, 1'b0, 1'b1, 1'b0);
         tick(); clear_ex();
         tick();
      end
      chk("sat_miscnt", 32'(o_mispred_cnt), 32'hFF);
      chk("sat_brcnt", 32'(o_br_cnt), 32'hFF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution and redirect controller for the pipelined RV32I core. Sits in EX beside the branch comparator: it drives the comparator's signed/unsigned select, evaluates the six conditional-branch conditions plus unconditional jumps, and detects mispredictions against the fetch-time prediction. On a misprediction it issues a registered redirect/flush to fetch through a ready/valid handshake. It also holds an optional 2-bit branch history table and performance counters.

## Interface
- BHT_IDX_W, 4: log2 of BHT entries (16)
- CNT_W, 16: width of performance counters
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_ex_valid  in  1  EX stage holds a valid instruction
- i_ex_is_br  in  1  instruction is a conditional branch
- i_ex_is_jmp  in  1  instruction is JAL/JALR
- i_ex_funct3  in  3  branch funct3
- i_ex_pc  in  32  PC of EX instruction
- i_ex_target  in  32  taken target from ALU
- i_ex_pred_taken  in  1  prediction carried from fetch
- o_br_un  out  1  to comparator; 1 = unsigned compare
- i_br_less, i_br_equal  in  1 each  comparator results for current EX operands
- i_if_pc  in  32  fetch PC for prediction lookup
- o_if_pred_taken  out  1  prediction for i_if_pc
- o_redirect_valid  out  1  redirect request to fetch
- o_redirect_pc  out  32  corrected next PC
- i_redirect_ready  in  1  fetch accepts redirect
- o_flush  out  1  one-cycle pulse, kill IF/ID
- o_stall  out  1  freeze front end while redirect pending
- o_br_cnt  out  CNT_W  resolved conditional branches
- o_mispred_cnt  out  CNT_W  mispredictions (branches and jumps)

## Operation
- o_br_un = i_ex_funct3[1] (combinational).
- Taken: 000 equal; 001 !equal; 100 less; 101 !less; 110 less; 111 !less; 010/011 illegal → not taken, no BHT update, not counted. Jump → always taken.
- Resolve event: i_ex_valid & (i_ex_is_br | i_ex_is_jmp) & state==IDLE. Events in state REDIRECT are ignored.
- Mispredict = resolve & (taken != i_ex_pred_taken). Next PC = taken ? i_ex_target : i_ex_pc + 32'd4 (mod 2^32).
- FSM: IDLE → REDIRECT on mispredict, latching o_redirect_pc. REDIRECT → IDLE on i_redirect_ready. Outputs in REDIRECT: o_redirect_valid=1, o_stall=!i_redirect_ready. o_flush=1 only on the first REDIRECT cycle.
- BHT: 2^BHT_IDX_W 2-bit saturating counters, indexed pc[BHT_IDX_W+1:2]. Predict taken = counter[1]. On a resolve of a legal conditional branch: increment if taken, decrement otherwise, saturating at 3/0. Jumps do not update.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update value (no bypass).
- Counters saturate at all-ones. o_br_cnt counts legal conditional resolves. o_mispred_cnt counts mispredicts.

## Timing
- Resolve decision is combinational in EX cycle N. Redirect/flush are visible from cycle N+1 (registered).
- If ready is high in cycle N+1, the redirect is accepted in one cycle, and a new resolve is possible in cycle N+2.
- o_redirect_pc is stable while o_redirect_valid=1.
- BHT and counter updates are written at the edge ending cycle N and are visible in cycle N+1.
- Reset (any state, including mid-REDIRECT) at the next edge: state IDLE, o_redirect_valid=0, o_redirect_pc=0, o_flush=0, o_stall=0, counters=0, all BHT entries=2'b01 (weakly not-taken). o_if_pred_taken=0 after reset.

## Configuration
- BRANCH_CTRL_BHT_EN defined: BHT present, o_if_pred_taken driven from the table as above.
- BRANCH_CTRL_BHT_EN undefined: no BHT storage, o_if_pred_taken tied 0 (static not-taken). Mispredict reduces to resolve & taken. All other behaviour is unchanged.

## Test plan
- BLT (100), less=1, pred 0, pc=0x100, target=0x80 → next cycle redirect_valid=1, redirect_pc=0x80, flush=1 for one cycle, mispred_cnt=1, br_cnt=1.
- BGEU (111), less=1, pred 1, pc=0x200 → o_br_un=1, redirect_pc=0x204, mispredict counted. BEQ with equal=1 and pred 1 → no redirect.
- Redirect with ready held low 3 cycles → valid and stall high 3 cycles, flush only in the first, pc stable. A branch presented during the wait is ignored. Ready=1 → IDLE next cycle.
- BHT_EN: branch at pc=0x40 taken twice → entry 01→10→11, lookup i_if_pc=0x40 gives 1. Lookup at pc=0x80 (aliases when BHT_IDX_W=4) also gives 1. Same-cycle update and lookup of one index returns the old value.
- Reset asserted mid-REDIRECT → all outputs and counters 0 after the edge. Drive 2^CNT_W+2 mispredicts → o_mispred_cnt holds 0xFFFF.
- funct3=010 with valid branch → no redirect, no count, no BHT change. JAL with pred 0 → redirect to target, BHT unchanged.
